ntt_poly_buffer: RTL and testbench
==================================

Name: ntt_poly_buffer

Overview:
- Memory-side responder for the NTT memory wrapper: owns the coefficient storage that the wrapper reads and writes.
- Accepts a polynomial from the host as a valid/ready stream and serves the wrapper's read addresses.
- Captures the wrapper's bit-reversed write-backs, then streams the result to the host in natural order.
- Sits between the host/DMA stream and one ntt_memory_wrapper instance; it also sequences that instance's start and reset.

Parameters:
- LOGQ, 64: coefficient width in bits.
- LOGN, 8: log2 of polynomial length N = 2**LOGN.
- AW, derived: address width = ((LOGN<9) ? 9 : LOGN) + 1, matching the wrapper's address ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- go  in  1  command pulse; starts load→run→drain, honoured only in IDLE
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last drain handshake
- in_valid  in  1  host load data valid
- in_ready  out  1  buffer can accept a load word
- in_data  in  LOGQ  load coefficient, natural order
- out_valid  out  1  drain data valid
- out_ready  in  1  host accepts drain word
- out_data  out  LOGQ  result coefficient, natural order 0..N-1
- ntt_rst  out  1  reset to wrapper
- ntt_start  out  1  start level to wrapper
- ntt_read_address  in  AW  wrapper read address
- ntt_rdata  out  LOGQ  read data to wrapper
- ntt_write_address  in  AW  wrapper write address
- ntt_wea  in  1  wrapper write enable
- ntt_wdata  in  LOGQ  wrapper write data
- ntt_finish  in  1  wrapper finish level

Behaviour:
- Storage: two banks of N×LOGQ. Bank A holds the input and is read by the wrapper; bank B holds the output and is written by the wrapper. The split removes in-place read/write hazards.
- FSM states: IDLE, LOAD, RUN, DRAIN.
  - IDLE→LOAD on go.
  - LOAD→RUN after the N-th load handshake.
  - RUN→DRAIN on the first cycle ntt_finish=1.
  - DRAIN→IDLE after the N-th out handshake.
- Reset values: state IDLE, all counters 0, in_ready=0, out_valid=0, out_data=0, ntt_rdata=0, ntt_start=0, ntt_rst=1, busy=0, done=0. Memory contents are not cleared.
- ntt_rst: equals 1 in IDLE and LOAD, 0 in RUN and DRAIN. This guarantees the wrapper's address counters are zero at every run start.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) writes bank A[load_cnt] and increments load_cnt.
  - in_ready drops in the cycle after the N-th handshake.
- RUN:
  - ntt_start=1 for the whole state, 0 in every other state.
  - Read port: ntt_rdata <= A[ntt_read_address[LOGN-1:0]] every cycle, 1-cycle registered latency. If ntt_read_address >= N, ntt_rdata <= 0.
  - Write port: if ntt_wea and ntt_write_address < N, write B[ntt_write_address[LOGN-1:0]] <= ntt_wdata. Writes with address >= N are ignored.
  - Writes are also accepted in the entry cycle of DRAIN, because the wrapper's last wea coincides with its finish edge.
- DRAIN:
  - Reads bank B at drain_rd_cnt 0..N-1 into a 2-entry output FIFO so out_valid/out_data stay stable under backpressure.
  - out_data changes only after a handshake.
  - No bubbles while out_ready=1: after the first word, throughput is 1 word/cycle.
  - First out_valid comes at most 2 cycles after entering DRAIN.
  - Drain reads begin 1 cycle after DRAIN entry, so the final wrapper write is visible.
- done: one-cycle pulse in the cycle after the N-th out handshake, coincident with return to IDLE.
- Boundary rules:
  - go outside IDLE is ignored.
  - in_valid outside LOAD is ignored, with in_ready=0.
  - ntt_finish outside RUN is ignored.
  - Mid-operation rst: immediately IDLE, ntt_start=0, ntt_rst=1, FIFO flushed, out_valid=0.
  - Counters are LOGN+1 bits and never wrap; the terminal count is N.

Test Plan:
- LOGN=4, Q=7681, wrapper model in loop: go, load x[i]=i for i=0..15 with in_valid always high → in_ready high for exactly 16 cycles; ntt_start rises the cycle after the 16th handshake; drained output matches a golden NTT of 0..15; done pulses once.
- Random in_valid gaps (50%) during load and random out_ready (30% low) during drain → identical output sequence; out_data is held stable whenever out_valid & !out_ready.
- Directed port check in RUN: ntt_read_address=5 → ntt_rdata=A[5] the next cycle; address 16 → 0; write to address 16 with wea → bank B unchanged.
- Final-write race: wrapper asserts its last wea (addr 15, data 0x1234) in the same cycle ntt_finish rises → drain word 15 = 0x1234.
- Assert rst after 6 drain handshakes → out_valid=0, busy=0, ntt_rst=1 next cycle; a following go/load/run produces a correct full result.
- go pulses during LOAD and RUN, and ntt_finish pulse in IDLE → no state change; exactly one done per accepted go.

Source files
------------

// File: rtl/ntt_poly_buffer.sv
// ntt_poly_buffer: two-bank coefficient store for one ntt_memory_wrapper; loads a polynomial from the host,
// serves the wrapper's reads and bit-reversed write-backs, then drains the result in natural order.
module ntt_poly_buffer #(
    parameter int LOGQ = 64,
    parameter int LOGN = 8,
    parameter int AW   = ((LOGN < 9) ? 9 : LOGN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    output logic            busy,
    output logic            done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_data,
    output logic            ntt_rst,
    output logic            ntt_start,
    input  logic [AW-1:0]   ntt_read_address,
    output logic [LOGQ-1:0] ntt_rdata,
    input  logic [AW-1:0]   ntt_write_address,
    input  logic            ntt_wea,
    input  logic [LOGQ-1:0] ntt_wdata,
    input  logic            ntt_finish
);
    localparam int N = 1 << LOGN;
    localparam logic [LOGN:0] CNT_N    = (LOGN+1)'(N);
    localparam logic [LOGN:0] CNT_LAST = (LOGN+1)'(N - 1);
    localparam logic [AW-1:0] ADDR_N   = AW'(N);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [LOGN:0]   load_cnt_q, load_cnt_d;
    logic [LOGN:0]   rd_cnt_q, rd_cnt_d;
    logic [LOGN:0]   out_cnt_q, out_cnt_d;
    logic            arm_q, arm_d;
    logic            done_q, done_d;
    logic [1:0]      fcnt_q, fcnt_d;
    logic [LOGQ-1:0] f0_q, f0_d;
    logic [LOGQ-1:0] f1_q, f1_d;
    logic [LOGQ-1:0] ntt_rdata_q, ntt_rdata_d;

    logic [LOGQ-1:0] bank_a [N];
    logic [LOGQ-1:0] bank_b [N];

    logic            in_hs, pop, push, b_we;
    logic [LOGQ-1:0] b_rd;

    assign in_hs = state_q == LOAD && in_valid;
    assign pop   = fcnt_q != 2'd0 && out_ready;
    // arm_q is low only in the DRAIN entry cycle, where the wrapper's final write may still land
    assign b_we  = ntt_wea && ntt_write_address < ADDR_N && (state_q == RUN || (state_q == DRAIN && !arm_q));
    assign push  = state_q == DRAIN && arm_q && rd_cnt_q != CNT_N && (fcnt_q != 2'd2 || pop);
    assign b_rd  = bank_b[rd_cnt_q[LOGN-1:0]];

    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign in_ready  = state_q == LOAD;
    assign out_valid = fcnt_q != 2'd0;
    assign out_data  = f0_q;
    assign ntt_rst   = state_q == IDLE || state_q == LOAD;
    assign ntt_start = state_q == RUN;
    assign ntt_rdata = ntt_rdata_q;

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_cnt_d   = out_cnt_q;
        arm_d       = arm_q;
        done_d      = 1'b0;
        ntt_rdata_d = ntt_read_address < ADDR_N ? bank_a[ntt_read_address[LOGN-1:0]] : '0;
        case (state_q)
            IDLE: begin
                state_d    = go ? LOAD : IDLE;
                load_cnt_d = '0;
            end
            LOAD: begin
                load_cnt_d = in_hs ? load_cnt_q + 1'b1 : load_cnt_q;
                state_d    = in_hs && load_cnt_q == CNT_LAST ? RUN : LOAD;
            end
            RUN: begin
                state_d   = ntt_finish ? DRAIN : RUN;
                rd_cnt_d  = '0;
                out_cnt_d = '0;
                arm_d     = 1'b0;
            end
            DRAIN: begin
                arm_d     = 1'b1;
                rd_cnt_d  = push ? rd_cnt_q + 1'b1 : rd_cnt_q;
                out_cnt_d = pop ? out_cnt_q + 1'b1 : out_cnt_q;
                done_d    = pop && out_cnt_q == CNT_LAST;
                state_d   = done_d ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
        // two-entry output FIFO: f0 is the head presented on out_data
        fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop};
        f0_d   = pop ? (fcnt_q == 2'd2 ? f1_q : (push ? b_rd : f1_q)) : (push && fcnt_q == 2'd0 ? b_rd : f0_q);
        f1_d   = push && (pop ? fcnt_q == 2'd2 : fcnt_q == 2'd1) ? b_rd : f1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            out_cnt_q   <= '0;
            arm_q       <= 1'b0;
            done_q      <= 1'b0;
            fcnt_q      <= 2'd0;
            f0_q        <= '0;
            f1_q        <= '0;
            ntt_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_cnt_q   <= out_cnt_d;
            arm_q       <= arm_d;
            done_q      <= done_d;
            fcnt_q      <= fcnt_d;
            f0_q        <= f0_d;
            f1_q        <= f1_d;
            ntt_rdata_q <= ntt_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs) bank_a[load_cnt_q[LOGN-1:0]] <= in_data;
        if (b_we) bank_b[ntt_write_address[LOGN-1:0]] <= ntt_wdata;
    end
endmodule

// File: tb/tb_ntt_poly_buffer.sv
// tb_ntt_poly_buffer: drives ntt_poly_buffer with a host model and an NTT wrapper model (q=7681, N=16),
// scoreboarding drained coefficients against a golden NTT of the loaded polynomial.
module tb_ntt_poly_buffer;
    localparam int LOGQ = 16;
    localparam int LOGN = 4;
    localparam int AW   = 10;
    localparam int N    = 16;
    localparam int Q    = 7681;

    typedef logic [LOGQ-1:0] vec_t [N];

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            go = 1'b0;
    logic            busy, done, in_ready, out_valid, ntt_rst, ntt_start;
    logic            in_valid = 1'b0;
    logic [LOGQ-1:0] in_data = '0;
    logic            out_ready = 1'b0;
    logic [LOGQ-1:0] out_data, ntt_rdata;
    logic [AW-1:0]   ntt_read_address = '0;
    logic [AW-1:0]   ntt_write_address = '0;
    logic            ntt_wea = 1'b0;
    logic [LOGQ-1:0] ntt_wdata = '0;
    logic            ntt_finish = 1'b0;

    int              n_chk = 0;
    int              n_pass = 0;
    int              done_cnt = 0;
    int              runs = 0;
    longint          omega;
    vec_t            x;
    logic [LOGQ-1:0] exp_q [$];

    always #5 clk = ~clk;

    ntt_poly_buffer #(.LOGQ(LOGQ), .LOGN(LOGN)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ntt_rst(ntt_rst), .ntt_start(ntt_start),
        .ntt_read_address(ntt_read_address), .ntt_rdata(ntt_rdata),
        .ntt_write_address(ntt_write_address), .ntt_wea(ntt_wea), .ntt_wdata(ntt_wdata),
        .ntt_finish(ntt_finish)
    );

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint pw(input longint b, input int e);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * b % Q;
        return r;
    endfunction

    function automatic int brev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < LOGN; i++) r |= ((v >> i) & 1) << (LOGN - 1 - i);
        return r;
    endfunction

    task automatic ntt(input vec_t a, output vec_t y);
        longint s;
        for (int k = 0; k < N; k++) begin
            s = 0;
            for (int i = 0; i < N; i++) s = (s + longint'(a[i]) * pw(omega, (i * k) % N)) % Q;
            y[k] = LOGQ'(s);
        end
    endtask

    task automatic prep(input bit rnd, input bit race);
        vec_t g;
        for (int i = 0; i < N; i++) x[i] = rnd ? LOGQ'($urandom_range(Q - 1)) : LOGQ'(i);
        ntt(x, g);
        if (race) begin
            g[15] = 16'h1234;
            g[14] = 16'h0777;
        end
        for (int i = 0; i < N; i++) exp_q.push_back(g[i]);
    endtask

    task automatic run_load(input int gap, output int rdy);
        int i, guard;
        i = 0;
        guard = 0;
        rdy = 0;
        go = 1'b1;
        tick;
        go = 1'b0;
        while (i < N && guard < 500) begin
            in_valid = $urandom_range(99) >= gap;
            in_data = x[i];
            go = guard == 3;
            rdy += int'(in_ready);
            if (in_valid && in_ready) i++;
            tick;
            guard++;
        end
        in_valid = 1'b0;
        go = 1'b0;
        chk("load_count", i, N);
        chk("in_ready_drop", in_ready, 0);
        chk("start_rise", ntt_start, 1);
        chk("ntt_rst_run", ntt_rst, 0);
    endtask

    task automatic run_wrap(input bit race);
        vec_t a, y;
        ntt_read_address = 5;
        tick;
        chk("rd_addr5", ntt_rdata, x[5]);
        ntt_read_address = 16;
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("rd_addr16", ntt_rdata, 0);
        chk("start_held", ntt_start, 1);
        for (int i = 0; i < N; i++) begin
            ntt_read_address = AW'(i);
            tick;
            a[i] = ntt_rdata;
        end
        ntt_read_address = '0;
        ntt(a, y);
        for (int j = 0; j < N; j++) begin
            ntt_write_address = AW'(brev(j));
            ntt_wea = 1'b1;
            ntt_wdata = y[brev(j)];
            if (j == N - 1) begin
                ntt_finish = 1'b1;
                if (race) ntt_wdata = 16'h1234;
            end
            tick;
            if (j == 0) begin
                ntt_write_address = 16;
                ntt_wdata = 16'hdead;
                tick;
            end
        end
        ntt_finish = 1'b0;
        ntt_write_address = 14;
        ntt_wdata = 16'h0777;
        ntt_wea = race;
    endtask

    task automatic run_drain(input int low, input int abort_at);
        int cnt, guard, first, bubbles;
        bit hold;
        logic [LOGQ-1:0] held, e;
        cnt = 0;
        guard = 0;
        first = -1;
        bubbles = 0;
        hold = 1'b0;
        held = '0;
        while (cnt < N && guard < 400) begin
            out_ready = $urandom_range(99) >= low;
            if (out_valid && first < 0) first = guard;
            if (first >= 0 && !out_valid) bubbles++;
            if (hold && out_valid) chk("hold_stable", out_data, held);
            hold = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else e = 'x;
                chk("drain_word", out_data, e);
                cnt++;
            end
            tick;
            guard++;
            ntt_wea = 1'b0;
            if (cnt == abort_at) break;
        end
        out_ready = 1'b0;
        if (abort_at < N) begin
            rst = 1'b1;
            tick;
            rst = 1'b0;
            chk("abort_out_valid", out_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_ntt_rst", ntt_rst, 1);
            chk("abort_ntt_start", ntt_start, 0);
            exp_q.delete();
        end else begin
            runs++;
            chk("drain_count", cnt, N);
            chk("first_valid_le2", first >= 0 && first <= 2, 1);
            if (low == 0) chk("no_bubbles", bubbles, 0);
            chk("done_pulse", done, 1);
            chk("idle_after", busy, 0);
            tick;
            chk("done_low", done, 0);
        end
    endtask

    initial begin
        int rdy;
        longint g;
        g = 2;
        omega = pw(g, (Q - 1) / N);
        while (pw(omega, N / 2) == 1 && g < 100) begin
            g++;
            omega = pw(g, (Q - 1) / N);
        end
        repeat (3) tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rdata", ntt_rdata, 0);
        chk("rst_ntt_start", ntt_start, 0);
        chk("rst_ntt_rst", ntt_rst, 1);
        rst = 1'b0;
        tick;
        ntt_finish = 1'b1;
        tick;
        ntt_finish = 1'b0;
        chk("finish_idle_busy", busy, 0);
        chk("finish_idle_start", ntt_start, 0);

        prep(1'b0, 1'b0);
        run_load(0, rdy);
        chk("in_ready_cycles", rdy, N);
        run_wrap(1'b0);
        run_drain(0, N);

        prep(1'b1, 1'b0);
        run_load(50, rdy);
        run_wrap(1'b0);
        run_drain(30, N);

        prep(1'b1, 1'b1);
        run_load(0, rdy);
        run_wrap(1'b1);
        run_drain(30, N);

        prep(1'b1, 1'b0);
        run_load(0, rdy);
        run_wrap(1'b0);
        run_drain(0, 6);

        prep(1'b1, 1'b0);
        run_load(20, rdy);
        run_wrap(1'b0);
        run_drain(30, N);

        tick;
        chk("done_count", done_cnt, runs);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
